ccff_chain_checker: RTL

Synthesizable built-in self-check engine for FPGA configuration chains. It drives a programmable test pattern into up to `N_CHAINS` independent `ccff_head` inputs and compares each `ccff_tail` against the same pattern delayed by that chain's programmed length. Per-chain mismatch counters and a pass/fail summary are reported. It sits beside `fpga_top` and replaces hand-written marker testbenches with one parametrised, mode-selectable checker usable in simulation and on silicon.

---
 rtl/ccff_check_pkg.sv | 61 ++++++
 rtl/ccff_tail_checker.sv | 55 +++++
 rtl/ccff_chain_checker.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ccff_check_pkg.sv
// Shared types, constants and pattern helpers for the configuration-chain
// self-check engine. The head generator and every tail checker advance the
// same pattern state through pat_next, so both sides stay bit-identical.
package ccff_check_pkg;

  typedef enum logic [1:0] {
    MODE_MARKER = 2'd0,
    MODE_PRBS7  = 2'd1,
    MODE_ZERO   = 2'd2,
    MODE_ONE    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Width of the generic pattern state: holds the marker down-counter
  // (PER_W bits) or the 7-bit PRBS register.
  localparam int PAT_W = 16;

  // PRBS7, x^7 + x^6 + 1, output taken from bit 6.
  localparam logic [6:0] PRBS_SEED  = 7'h7F;
  localparam int         PRBS_TAP_A = 6;
  localparam int         PRBS_TAP_B = 5;

  // Pattern state for index 0. The marker uses a down-counter that fires at
  // terminal count 0, so starting at period-1 fires on i mod period == period-1.
  function automatic logic [PAT_W-1:0] pat_init(mode_e m, logic [PAT_W-1:0] per_m1);
    logic [PAT_W-1:0] r;
    if (m == MODE_MARKER) r = per_m1;
    else                  r = {{(PAT_W-7){1'b0}}, PRBS_SEED};
    return r;
  endfunction

  // Pattern bit presented by a given state.
  function automatic logic pat_bit(mode_e m, logic [PAT_W-1:0] s);
    logic b;
    case (m)
      MODE_MARKER: b = (s == '0);
      MODE_PRBS7:  b = s[6];
      MODE_ZERO:   b = 1'b0;
      default:     b = 1'b1;
    endcase
    return b;
  endfunction

  // Advance the pattern state by one index.
  function automatic logic [PAT_W-1:0] pat_next(mode_e m, logic [PAT_W-1:0] per_m1,
                                                logic [PAT_W-1:0] s);
    logic [PAT_W-1:0] r;
    case (m)
      MODE_MARKER: r = (s == '0) ? per_m1 : s - PAT_W'(1);
      MODE_PRBS7:  r = {{(PAT_W-7){1'b0}}, s[5:0], s[PRBS_TAP_A] ^ s[PRBS_TAP_B]};
      default:     r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ccff_tail_checker.sv
// Per-chain tail checker: a private reference generator that starts at
// i == len, the compare enable, a saturating mismatch counter and a sticky
// fail flag. fail_nxt exposes the flag value after the current edge so the
// top can form pass on the same edge as the last compare.
module ccff_tail_checker
  import ccff_check_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int ERR_W = 12
) (
  input  logic             prog_clk,
  input  logic             pReset,
  input  logic             clear,
  input  logic             sample,
  input  mode_e            mode,
  input  logic [PAT_W-1:0] per_m1,
  input  logic [PAT_W-1:0] init_s,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] idx,
  input  logic             tail,
  output logic [ERR_W-1:0] err_count,
  output logic             fail,
  output logic             fail_nxt
);

  logic [PAT_W-1:0] ref_s;
  logic             cmp_en;
  logic             mism;

  assign cmp_en   = sample && (len != '0) && (idx >= len);
  assign mism     = cmp_en && (tail != pat_bit(mode, ref_s));
  assign fail_nxt = fail | mism;

  // Reference generator: seeded on run start, advanced once per compare.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset)     ref_s <= '0;
    else if (clear)  ref_s <= init_s;
    else if (cmp_en) ref_s <= pat_next(mode, per_m1, ref_s);
  end

  // Saturating mismatch counter and sticky fail flag, cleared on run start.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      err_count <= '0;
      fail      <= 1'b0;
    end else if (clear) begin
      err_count <= '0;
      fail      <= 1'b0;
    end else if (mism) begin
      if (err_count != '1) err_count <= err_count + ERR_W'(1);
      fail <= 1'b1;
    end
  end

endmodule

// File: rtl/ccff_chain_checker.sv
// Built-in self-check engine for configuration chains. Drives a pattern into
// every enabled ccff_head and checks each ccff_tail against the same pattern
// delayed by that chain's programmed length.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; results of the last run held
// S_SHIFT | heads driven with pat(i), tails compared, i advances
// S_DONE  | one-cycle done pulse, pass valid, heads back at 0
module ccff_chain_checker
  import ccff_check_pkg::*;
#(
  parameter int N_CHAINS = 4,
  parameter int LEN_W    = 16,
  parameter int PER_W    = 8,
  parameter int ERR_W    = 12
) (
  input  logic                      prog_clk,
  input  logic                      pReset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [1:0]                mode,
  input  logic [PER_W-1:0]          period,
  input  logic [LEN_W-1:0]          n_shift,
  input  logic [N_CHAINS*LEN_W-1:0] chain_len,
  input  logic [N_CHAINS-1:0]       ccff_tail,
  output logic [N_CHAINS-1:0]       ccff_head,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [N_CHAINS-1:0]       fail_mask,
  output logic [N_CHAINS-1:0]       nocheck_mask,
  output logic [N_CHAINS*ERR_W-1:0] err_count
);

  state_e                    state;
  mode_e                     mode_q;
  mode_e                     mode_in;
  logic [PAT_W-1:0]          per_m1_q;
  logic [PAT_W-1:0]          per_m1_in;
  logic [PAT_W-1:0]          init_in;
  logic [PAT_W-1:0]          gen_s;
  logic [LEN_W-1:0]          n_shift_q;
  logic [LEN_W-1:0]          idx;
  logic [N_CHAINS*LEN_W-1:0] len_q;
  logic [N_CHAINS-1:0]       en_in;
  logic [N_CHAINS-1:0]       en_q;
  logic [N_CHAINS-1:0]       nocheck_in;
  logic [N_CHAINS-1:0]       fail_nxt;
  logic                      accept;
  logic                      sample;
  logic                      last;

  assign mode_in   = mode_e'(mode);
  // A period of 0 behaves as period 1 (marker on every cycle).
  assign per_m1_in = (period == '0) ? '0 : PAT_W'(period) - PAT_W'(1);
  assign init_in   = pat_init(mode_in, per_m1_in);
  assign accept    = (state == S_IDLE) && start && !abort;
  assign sample    = (state == S_SHIFT) && !abort;
  assign last      = (idx + LEN_W'(1)) == n_shift_q;

  // Chain enables from the live inputs (used at start) and the latched copy.
  always_comb begin
    en_in      = '0;
    en_q       = '0;
    nocheck_in = '0;
    for (int k = 0; k < N_CHAINS; k++) begin
      en_in[k]      = chain_len[k*LEN_W +: LEN_W] != '0;
      en_q[k]       = len_q[k*LEN_W +: LEN_W] != '0;
      nocheck_in[k] = en_in[k] && (chain_len[k*LEN_W +: LEN_W] >= n_shift);
    end
  end

  // Sequencer FSM with head generator; all outputs registered.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state        <= S_IDLE;
      mode_q       <= MODE_MARKER;
      per_m1_q     <= '0;
      n_shift_q    <= '0;
      len_q        <= '0;
      idx          <= '0;
      gen_s        <= '0;
      ccff_head    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      nocheck_mask <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      ccff_head <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q       <= mode_in;
            per_m1_q     <= per_m1_in;
            n_shift_q    <= n_shift;
            len_q        <= chain_len;
            nocheck_mask <= nocheck_in;
            idx          <= '0;
            if (n_shift == '0) begin
              // Nothing to shift: report immediately, trivially passing.
              state     <= S_DONE;
              done      <= 1'b1;
              pass      <= 1'b1;
              ccff_head <= '0;
            end else begin
              state     <= S_SHIFT;
              busy      <= 1'b1;
              pass      <= 1'b0;
              ccff_head <= pat_bit(mode_in, init_in) ? en_in : '0;
              gen_s     <= pat_next(mode_in, per_m1_in, init_in);
            end
          end
        end
        S_SHIFT: begin
          if (last) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (fail_nxt == '0);
            ccff_head <= '0;
          end else begin
            idx       <= idx + LEN_W'(1);
            ccff_head <= pat_bit(mode_q, gen_s) ? en_q : '0;
            gen_s     <= pat_next(mode_q, per_m1_q, gen_s);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CHAINS; k++) begin : g_chk
    ccff_tail_checker #(
      .LEN_W (LEN_W),
      .ERR_W (ERR_W)
    ) u_chk (
      .prog_clk  (prog_clk),
      .pReset    (pReset),
      .clear     (accept),
      .sample    (sample),
      .mode      (mode_q),
      .per_m1    (per_m1_q),
      .init_s    (init_in),
      .len       (len_q[k*LEN_W +: LEN_W]),
      .idx       (idx),
      .tail      (ccff_tail[k]),
      .err_count (err_count[k*ERR_W +: ERR_W]),
      .fail      (fail_mask[k]),
      .fail_nxt  (fail_nxt[k])
    );
  end

endmodule
